// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared ALU control codes, ALU_op classes, opcodes and sequencer states
package alu_ctrl_pkg;

   localparam logic [2:0] CTRL_PASS_B = 3'b000;
   localparam logic [2:0] CTRL_ADD    = 3'b010;
   localparam logic [2:0] CTRL_SUB    = 3'b011;
   localparam logic [2:0] CTRL_AND    = 3'b100;
   localparam logic [2:0] CTRL_ORR    = 3'b101;
   localparam logic [2:0] CTRL_EOR    = 3'b110;
   localparam logic [2:0] CTRL_MUL    = 3'b111;

   localparam logic [1:0] ALUOP_PASS   = 2'b00;
   localparam logic [1:0] ALUOP_ADD    = 2'b01;
   localparam logic [1:0] ALUOP_SUB    = 2'b10;
   localparam logic [1:0] ALUOP_DECODE = 2'b11;

   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_SUB = 11'b11001011000;
   localparam logic [10:0] OPC_AND = 11'b10001010000;
   localparam logic [10:0] OPC_ORR = 11'b10101010000;
   localparam logic [10:0] OPC_EOR = 11'b11001010000;
   localparam logic [10:0] OPC_MUL = 11'b10011011000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_MUL
   } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational ALU_op/opcode decode; MUL recognised only with ALU_CTRL_SEQ_MUL_EN
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
#(
   parameter int CTRL_W = 3,
   parameter int OPC_W  = 11
) (
   input  logic [1:0]        ALU_op,
   input  logic [OPC_W-1:0]  instruction,
   output logic [CTRL_W-1:0] ctrl,
   output logic              is_mul,
   output logic              illegal
);

   logic [2:0] code;

   always_comb begin
      code    = CTRL_PASS_B;
      is_mul  = 1'b0;
      illegal = 1'b0;
      case (ALU_op)
         ALUOP_PASS: code = CTRL_PASS_B;
         ALUOP_ADD:  code = CTRL_ADD;
         ALUOP_SUB:  code = CTRL_SUB;
         default: begin
            if (instruction == OPC_W'(OPC_ADD))      code = CTRL_ADD;
            else if (instruction == OPC_W'(OPC_SUB)) code = CTRL_SUB;
            else if (instruction == OPC_W'(OPC_AND)) code = CTRL_AND;
            else if (instruction == OPC_W'(OPC_ORR)) code = CTRL_ORR;
            else if (instruction == OPC_W'(OPC_EOR)) code = CTRL_EOR;
`ifdef ALU_CTRL_SEQ_MUL_EN
            else if (instruction == OPC_W'(OPC_MUL)) begin
               code   = CTRL_MUL;
               is_mul = 1'b1;
            end
`endif
            else illegal = 1'b1;
         end
      endcase
   end

   assign ctrl = CTRL_W'(code);

endmodule

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - ALU control sequencer with output hold, flush and optional multi-cycle MUL
// (MUL path enabled by defining ALU_CTRL_SEQ_MUL_EN)
module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter int CTRL_W     = 3,
   parameter int OPC_W      = 11,
   parameter int MUL_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [1:0]        ALU_op,
   input  logic [OPC_W-1:0]  instruction,
   input  logic              flush,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ALU_ctrl,
   output logic              ex_is_mul,
   output logic              ex_illegal,
   output logic              busy
);

   if (CTRL_W < 3 || MUL_CYCLES < 1) begin : g_param_check
      $error("alu_ctrl_seq: CTRL_W must be >= 3 and MUL_CYCLES >= 1");
   end

   logic [CTRL_W-1:0] dec_ctrl;
   logic              dec_is_mul;
   logic              dec_illegal;
   logic              accept;
   state_t            state;

   alu_ctrl_decode #(
      .CTRL_W (CTRL_W),
      .OPC_W  (OPC_W)
   ) u_decode (
      .ALU_op      (ALU_op),
      .instruction (instruction),
      .ctrl        (dec_ctrl),
      .is_mul      (dec_is_mul),
      .illegal     (dec_illegal)
   );

   assign id_ready = (state == ST_IDLE) || ((state == ST_HOLD) && ex_ready);
   assign accept   = id_valid && id_ready;

`ifdef ALU_CTRL_SEQ_MUL_EN
   localparam int CNT_W = $clog2(MUL_CYCLES + 1);
   logic [CNT_W-1:0] cnt;
`else
   assign busy = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         ex_valid    <= 1'b0;
         ex_ALU_ctrl <= '0;
         ex_is_mul   <= 1'b0;
         ex_illegal  <= 1'b0;
`ifdef ALU_CTRL_SEQ_MUL_EN
         busy        <= 1'b0;
         cnt         <= '0;
`endif
      end else if (flush) begin
         // flush wins over a same-cycle accept: the incoming op is dropped
         state    <= ST_IDLE;
         ex_valid <= 1'b0;
`ifdef ALU_CTRL_SEQ_MUL_EN
         busy     <= 1'b0;
         cnt      <= '0;
`endif
      end else if (accept) begin
         ex_ALU_ctrl <= dec_ctrl;
         ex_is_mul   <= dec_is_mul;
         ex_illegal  <= dec_illegal;
`ifdef ALU_CTRL_SEQ_MUL_EN
         if (dec_is_mul && (MUL_CYCLES > 1)) begin
            state    <= ST_MUL;
            ex_valid <= 1'b0;
            busy     <= 1'b1;
            cnt      <= CNT_W'(MUL_CYCLES - 2);
         end else
`endif
         begin
            state    <= ST_HOLD;
            ex_valid <= 1'b1;
         end
      end else begin
         case (state)
            ST_HOLD: begin
               if (ex_ready) begin
                  state    <= ST_IDLE;
                  ex_valid <= 1'b0;
               end
            end
`ifdef ALU_CTRL_SEQ_MUL_EN
            ST_MUL: begin
               if (cnt == '0) begin
                  state    <= ST_HOLD;
                  ex_valid <= 1'b1;
                  busy     <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - self-checking bench for alu_ctrl_seq (honours ALU_CTRL_SEQ_MUL_EN)
module tb_alu_ctrl_seq;

   localparam int CTRL_W     = 3;
   localparam int OPC_W      = 11;
   localparam int MUL_CYCLES = 4;
`ifdef ALU_CTRL_SEQ_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   localparam logic [10:0] I_ADD = 11'b10001011000;
   localparam logic [10:0] I_SUB = 11'b11001011000;
   localparam logic [10:0] I_AND = 11'b10001010000;
   localparam logic [10:0] I_ORR = 11'b10101010000;
   localparam logic [10:0] I_EOR = 11'b11001010000;
   localparam logic [10:0] I_MUL = 11'b10011011000;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              id_valid = 1'b0;
   logic              id_ready;
   logic [1:0]        ALU_op = 2'b00;
   logic [OPC_W-1:0]  instruction = '0;
   logic              flush = 1'b0;
   logic              ex_ready = 1'b0;
   logic              ex_valid;
   logic [CTRL_W-1:0] ex_ALU_ctrl;
   logic              ex_is_mul;
   logic              ex_illegal;
   logic              busy;

   int errors = 0;
   int checks = 0;
   logic [7:0] want;

   // observed bundle: {id_ready, ex_valid, busy, ex_is_mul, ex_illegal, ex_ALU_ctrl}
   wire [7:0] obs = {id_ready, ex_valid, busy, ex_is_mul, ex_illegal, ex_ALU_ctrl};

   alu_ctrl_seq #(
      .CTRL_W     (CTRL_W),
      .OPC_W      (OPC_W),
      .MUL_CYCLES (MUL_CYCLES)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .ALU_op      (ALU_op),
      .instruction (instruction),
      .flush       (flush),
      .ex_ready    (ex_ready),
      .ex_valid    (ex_valid),
      .ex_ALU_ctrl (ex_ALU_ctrl),
      .ex_is_mul   (ex_is_mul),
      .ex_illegal  (ex_illegal),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // {ctrl[2:0], is_mul, illegal} straight from the decode table
   function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [10:0] ins);
      if (op == 2'b00) return 5'b000_00;
      if (op == 2'b01) return 5'b010_00;
      if (op == 2'b10) return 5'b011_00;
      case (ins)
         I_ADD:   return 5'b010_00;
         I_SUB:   return 5'b011_00;
         I_AND:   return 5'b100_00;
         I_ORR:   return 5'b101_00;
         I_EOR:   return 5'b110_00;
         I_MUL:   return MUL_EN ? 5'b111_10 : 5'b000_01;
         default: return 5'b000_01;
      endcase
   endfunction

   function automatic logic [7:0] out_word(input logic rdy, input logic vld, input logic bsy,
                                           input logic [4:0] d);
      return {rdy, vld, bsy, d[1], d[0], d[4:2]};
   endfunction

   task automatic drive(input logic v, input logic [1:0] op, input logic [10:0] ins,
                        input logic rdy, input logic fl);
      @(posedge clk);
      #1;
      id_valid = v; ALU_op = op; instruction = ins; ex_ready = rdy; flush = fl;
      @(negedge clk);
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, 2'($urandom), 11'($urandom), rdy, 1'b0);
   endtask

   task automatic reset_dut;
      @(posedge clk);
      #1;
      reset_n = 1'b0; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      #3;
      checks++;
      if (obs !== 8'b1000_0000) begin errors++; $display("FAIL reset_held: got %b want %b", obs, 8'b1000_0000); end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== 8'b1000_0000) begin errors++; $display("FAIL reset_release: got %b want %b", obs, 8'b1000_0000); end
   endtask

   task automatic test_simple_ops;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'(i), 11'($urandom), 1'b1, 1'b0);
         checks++;
         if (obs[7:6] !== 2'b10) begin errors++; $display("FAIL op%0d_accept: got %b want 10", i, obs[7:6]); end
         idle(1'b1);
         want = out_word(1'b1, 1'b1, 1'b0, ref_decode(2'(i), 11'h000));
         checks++;
         if (obs !== want) begin errors++; $display("FAIL op%0d_out: got %b want %b", i, obs, want); end
         idle(1'b1);
         checks++;
         if (obs[7:6] !== 2'b10) begin errors++; $display("FAIL op%0d_drop: got %b want 10", i, obs[7:6]); end
      end
   endtask

   task automatic test_hold_illegal;
      drive(1'b1, 2'b11, I_ORR, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 2'($urandom), 11'($urandom), 1'b0, 1'b0);
         checks++;
         if (obs !== 8'b0100_0101) begin errors++; $display("FAIL hold_%0d: got %b want %b", k, obs, 8'b0100_0101); end
      end
      idle(1'b1);
      checks++;
      if (obs !== 8'b1100_0101) begin errors++; $display("FAIL hold_release: got %b want %b", obs, 8'b1100_0101); end
      drive(1'b1, 2'b11, 11'h7FF, 1'b1, 1'b0);
      idle(1'b1);
      checks++;
      if (obs !== 8'b1100_1000) begin errors++; $display("FAIL illegal_out: got %b want %b", obs, 8'b1100_1000); end
      idle(1'b1);
   endtask

   task automatic test_mul;
      drive(1'b1, 2'b11, I_MUL, 1'b1, 1'b0);
`ifdef ALU_CTRL_SEQ_MUL_EN
      for (int c = 1; c <= MUL_CYCLES; c++) begin
         drive(c < MUL_CYCLES, 2'($urandom), 11'($urandom), 1'b1, 1'b0);
         want = (c < MUL_CYCLES) ? 8'b0011_0111 : 8'b1101_0111;
         checks++;
         if (obs !== want) begin errors++; $display("FAIL mul_cycle%0d: got %b want %b", c, obs, want); end
      end
`else
      idle(1'b1);
      checks++;
      if (obs !== 8'b1100_1000) begin errors++; $display("FAIL mul_disabled: got %b want %b", obs, 8'b1100_1000); end
`endif
      idle(1'b1);
      checks++;
      if (obs[7:5] !== 3'b100) begin errors++; $display("FAIL mul_done: got %b want 100", obs[7:5]); end
   endtask

   task automatic test_flush;
`ifdef ALU_CTRL_SEQ_MUL_EN
      drive(1'b1, 2'b11, I_MUL, 1'b1, 1'b0);
      idle(1'b1);
      drive(1'b0, 2'b00, 11'h000, 1'b1, 1'b1);
      checks++;
      if (obs[7:5] !== 3'b001) begin errors++; $display("FAIL flush_mul_c2: got %b want 001", obs[7:5]); end
      for (int c = 3; c <= MUL_CYCLES + 2; c++) begin
         idle(1'b1);
         checks++;
         if (obs[7:5] !== 3'b100) begin errors++; $display("FAIL flush_mul_c%0d: got %b want 100", c, obs[7:5]); end
      end
`endif
      drive(1'b1, 2'b01, 11'($urandom), 1'b0, 1'b0);
      drive(1'b0, 2'b00, 11'h000, 1'b0, 1'b1);
      checks++;
      if (obs[7:6] !== 2'b01) begin errors++; $display("FAIL flush_hold_pre: got %b want 01", obs[7:6]); end
      for (int c = 0; c < 3; c++) begin
         idle(1'b0);
         checks++;
         if (obs[7:5] !== 3'b100) begin errors++; $display("FAIL flush_hold_%0d: got %b want 100", c, obs[7:5]); end
      end
      drive(1'b1, 2'b01, 11'($urandom), 1'b1, 1'b1);
      for (int c = 0; c < 3; c++) begin
         idle(1'b1);
         checks++;
         if (obs[7:5] !== 3'b100) begin errors++; $display("FAIL flush_accept_%0d: got %b want 100", c, obs[7:5]); end
      end
   endtask

   task automatic test_async_reset;
      drive(1'b1, 2'b11, I_ORR, 1'b0, 1'b0);
      idle(1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (obs !== 8'b1000_0000) begin errors++; $display("FAIL reset_in_hold: got %b want %b", obs, 8'b1000_0000); end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      idle(1'b1);
      checks++;
      if (obs[7:5] !== 3'b100) begin errors++; $display("FAIL reset_hold_after: got %b want 100", obs[7:5]); end
`ifdef ALU_CTRL_SEQ_MUL_EN
      drive(1'b1, 2'b11, I_MUL, 1'b1, 1'b0);
      idle(1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (obs !== 8'b1000_0000) begin errors++; $display("FAIL reset_in_mul: got %b want %b", obs, 8'b1000_0000); end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int c = 0; c < MUL_CYCLES + 1; c++) begin
         idle(1'b1);
         checks++;
         if (obs[7:5] !== 3'b100) begin errors++; $display("FAIL reset_mul_after_%0d: got %b want 100", c, obs[7:5]); end
      end
`endif
   endtask

   task automatic test_back_to_back;
      drive(1'b1, 2'b01, 11'($urandom), 1'b1, 1'b0);
      drive(1'b1, 2'b10, 11'($urandom), 1'b1, 1'b0);
      checks++;
      if (obs !== 8'b1100_0010) begin errors++; $display("FAIL b2b_add: got %b want %b", obs, 8'b1100_0010); end
      idle(1'b1);
      checks++;
      if (obs !== 8'b1100_0011) begin errors++; $display("FAIL b2b_sub: got %b want %b", obs, 8'b1100_0011); end
      idle(1'b1);
      checks++;
      if (obs[7:6] !== 2'b10) begin errors++; $display("FAIL b2b_end: got %b want 10", obs[7:6]); end
   endtask

   task automatic test_random;
      logic [10:0] pool [6] = '{I_ADD, I_SUB, I_AND, I_ORR, I_EOR, I_MUL};
      bit          occ = 1'b0;
      int          ready_at = 0;
      logic [4:0]  item = '0;
      logic        v, rdy, fl, e_valid, e_busy, e_ready;
      logic [1:0]  op;
      logic [10:0] ins;
      int          sel;
      reset_dut();
      for (int n = 0; n < 600; n++) begin
         v   = ($urandom_range(0, 3) != 0);
         op  = 2'($urandom);
         sel = int'($urandom_range(0, 7));
         ins = (sel < 6) ? pool[sel] : 11'($urandom);
         rdy = ($urandom_range(0, 2) != 0);
         fl  = ($urandom_range(0, 15) == 0);
         drive(v, op, ins, rdy, fl);
         e_valid = occ && (n >= ready_at);
         e_busy  = occ && (n < ready_at);
         e_ready = !occ || (e_valid && rdy);
         checks++;
         if (obs[7:5] !== {e_ready, e_valid, e_busy})
            begin errors++; $display("FAIL rand_hs n=%0d: got %b want %b", n, obs[7:5], {e_ready, e_valid, e_busy}); end
         if (e_valid || e_busy) begin
            checks++;
            if (obs[4:0] !== {item[1], item[0], item[4:2]})
               begin errors++; $display("FAIL rand_data n=%0d: got %b want %b", n, obs[4:0], {item[1], item[0], item[4:2]}); end
         end
         if (fl) begin
            occ = 1'b0;
         end else if (e_ready && v) begin
            occ      = 1'b1;
            item     = ref_decode(op, ins);
            ready_at = n + ((item[1] && MUL_CYCLES > 1) ? MUL_CYCLES : 1);
         end else if (e_valid && rdy) begin
            occ = 1'b0;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_simple_ops();
      test_hold_illegal();
      test_mul();
      test_flush();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
